sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Sequences and shares the single-port 16x64K lookup/capture SRAM between three requesters: the flash-to-SRAM loader, the ADC capture path and the serial readout path.
- Owns the capture write pointer, discards the first ADC sample after each arm, and buffers ADC samples while the port is busy.
- Reports capture-full and overflow.
- Sits between the loader, the ADC front end, the readout shifter and the SRAM macro.

Parameters:
- AW, 16, SRAM address width.
- DW, 16, SRAM data width.
- CAP_BASE, 16'h0000, first capture address.
- CAP_LAST, 16'hFFFF, last capture address (inclusive, CAP_LAST >= CAP_BASE).
- FIFO_DEPTH, 2, ADC sample buffer entries (power of two, >= 2).
- DISCARD_FIRST, 1, number of ADC samples dropped after each arm.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-low reset.
- ld_busy, in, 1, loader owns the SRAM port while high.
- ld_wen, in, 1, loader write strobe.
- ld_addr, in, AW, loader address.
- ld_wdata, in, DW, loader write data.
- cap_start, in, 1, one-cycle pulse: arm a new capture.
- adc_valid, in, 1, one-cycle pulse: new ADC sample.
- adc_data, in, DW, ADC sample.
- rd_req, in, 1, readout read request (level, held until rd_gnt).
- rd_addr, in, AW, readout address (stable while rd_req is high).
- rd_gnt, out, 1, read issued to the SRAM this cycle.
- rd_valid, out, 1, rd_data valid; asserted one cycle after rd_gnt.
- rd_data, out, DW, read data.
- cap_busy, out, 1, capture armed and not yet full.
- cap_full, out, 1, capture region completely written.
- cap_ovf, out, 1, sticky flag: an ADC sample was dropped because the buffer was full.
- sram_wen, out, 1, SRAM write enable.
- sram_addr, out, AW, SRAM address.
- sram_wdata, out, DW, SRAM write data.
- sram_rdata, in, DW, SRAM read data (registered; 1-cycle latency).

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: rd_gnt, rd_valid, cap_busy, cap_full, cap_ovf and sram_wen go to 0; rd_data and sram_wdata go to 0; sram_addr goes to 0.
  - State: FSM to IDLE, FIFO emptied, write pointer to CAP_BASE, discard counter to 0.
  - Reset mid-capture abandons the capture with no further writes.
- FSM states: IDLE, CAPTURE, FULL.
  - IDLE/FULL + cap_start -> CAPTURE: write pointer = CAP_BASE; discard counter = DISCARD_FIRST; FIFO flushed; cap_full=0; cap_ovf=0.
  - CAPTURE + drain of the write at CAP_LAST -> FULL with cap_full=1. Samples arriving after that write are ignored and are not overflow.
  - cap_start during CAPTURE restarts the capture (same actions as from IDLE).
  - cap_busy = (state==CAPTURE).
- Sample intake (CAPTURE only):
  - adc_valid with discard counter > 0 decrements the counter; nothing is stored.
  - Otherwise the sample is pushed to the FIFO.
  - Push when the FIFO is full: sample dropped, cap_ovf=1.
  - Push and pop in the same cycle on a full FIFO is legal: no drop.
- Port priority, evaluated every cycle, exactly one owner:
  1. ld_busy=1: SRAM port mirrors ld_wen/ld_addr/ld_wdata combinationally; FIFO pop and rd_gnt are blocked. Samples keep buffering (overflow possible).
  2. FIFO not empty: pop one sample; sram_wen=1; sram_addr = write pointer; sram_wdata = sample; pointer +1 (no wrap past CAP_LAST).
  3. rd_req=1: rd_gnt=1; sram_wen=0; sram_addr = rd_addr.
  4. Otherwise: sram_wen=0; sram_addr holds its last value.
- Readout:
  - rd_valid=1 exactly one cycle after each rd_gnt; rd_data = sram_rdata in that cycle, held until the next rd_valid.
  - Back-to-back grants are allowed (one read per cycle).
  - Readout may starve while the FIFO drains; the worst case is FIFO_DEPTH cycles after ld_busy falls.
- Reads and writes never share a cycle. A read of an address written in the previous cycle returns the new data.
- ld_busy rising mid-capture is legal. The write pointer does not advance while the loader owns the port.

Decomposition:
- Shared package (sram_arb_pkg): AW/DW constants, FSM state encoding (IDLE=0, CAPTURE=1, FULL=2), CAP_BASE/CAP_LAST defaults.
- One sub-module: sample_fifo (synchronous FIFO, DEPTH x DW, push/pop/full/empty, simultaneous push+pop on full allowed). Arbitration and FSM stay in the top.

Test Plan:
- Loader pass-through: ld_busy=1, ld_wen=1, ld_addr=16'h0042, ld_wdata=16'hBEEF, rd_req=1 -> sram_wen=1, sram_addr=16'h0042, sram_wdata=16'hBEEF same cycle; rd_gnt=0 until ld_busy falls.
- Capture with discard: cap_start, then samples 16'h0001..16'h0004 on separate cycles, CAP_BASE=0 -> 16'h0001 dropped; writes of 2,3,4 to addresses 0,1,2.
- Full boundary: CAP_BASE=16'hFFFD, CAP_LAST=16'hFFFF, five samples after the discard -> writes to FFFD/FFFE/FFFF; cap_full=1 and cap_busy=0 the cycle after the FFFF write; later samples produce no write and leave cap_ovf=0.
- Overflow: ld_busy=1 during CAPTURE, three post-discard samples with FIFO_DEPTH=2 -> cap_ovf=1; after ld_busy falls, exactly two writes (first two samples) at consecutive addresses.
- Readout contention: FIFO holds 1 sample while rd_req=1, rd_addr=16'h0010 -> cycle N: ADC write; N+1: rd_gnt=1; N+2: rd_valid=1, rd_data = SRAM content at 16'h0010.
- Reset mid-capture: rst=0 for one cycle after two writes -> all outputs 0; cap_start then one post-discard sample -> write to CAP_BASE.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths, capture defaults and FSM encoding for the SRAM port arbiter
package sram_arb_pkg;

    localparam int SRAM_AW = 16;
    localparam int SRAM_DW = 16;

    localparam logic [15:0] CAP_BASE_DEF = 16'h0000;
    localparam logic [15:0] CAP_LAST_DEF = 16'hFFFF;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - small synchronous sample buffer; push on full is accepted when a pop frees a slot
module sample_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; stale entries are harmless because count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush discards everything buffered.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares the capture SRAM between loader, ADC capture and serial readout
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int            AW            = SRAM_AW,
    parameter int            DW            = SRAM_DW,
    parameter logic [AW-1:0] CAP_BASE      = CAP_BASE_DEF,
    parameter logic [AW-1:0] CAP_LAST      = CAP_LAST_DEF,
    parameter int            FIFO_DEPTH    = 2,
    parameter int            DISCARD_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_busy,
    input  logic          ld_wen,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          cap_start,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          cap_busy,
    output logic          cap_full,
    output logic          cap_ovf,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);
    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [15:0]   discard_cnt;
    logic [AW-1:0] addr_hold;
    logic [DW-1:0] wdata_hold;
    logic [DW-1:0] rd_hold;
    logic          rd_valid_q;
    logic          capturing;
    logic          own_ld;
    logic          own_wr;
    logic          own_rd;
    logic          last_wr;
    logic          take;
    logic          discard;
    logic          fifo_push;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ovf_set;
    logic [DW-1:0] fifo_rdata;

    assign capturing = (state == ST_CAPTURE);
    assign cap_busy  = capturing;
    assign cap_full  = (state == ST_FULL);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_valid_q ? sram_rdata : rd_hold;

    // Exactly one port owner per cycle: loader, then buffered samples, then readout.
    always_comb begin
        own_ld  = rst && ld_busy;
        own_wr  = rst && !ld_busy && capturing && !fifo_empty;
        own_rd  = rst && !ld_busy && !own_wr && rd_req;
        last_wr = own_wr && (wr_ptr == CAP_LAST);
    end

    // Sample intake: drop the first samples after arm, ignore anything once the last slot is written.
    always_comb begin
        take       = rst && capturing && adc_valid && !cap_start && !last_wr;
        discard    = take && (discard_cnt != '0);
        fifo_push  = take && (discard_cnt == '0);
        ovf_set    = fifo_push && fifo_full && !own_wr;
        fifo_flush = cap_start || last_wr;
    end

    // SRAM port mux; an idle port keeps presenting the last address and data.
    always_comb begin
        sram_wen   = 1'b0;
        sram_addr  = addr_hold;
        sram_wdata = wdata_hold;
        rd_gnt     = 1'b0;
        if (!rst) begin
            sram_addr  = '0;
            sram_wdata = '0;
        end else if (own_ld) begin
            sram_wen   = ld_wen;
            sram_addr  = ld_addr;
            sram_wdata = ld_wdata;
        end else if (own_wr) begin
            sram_wen   = 1'b1;
            sram_addr  = wr_ptr;
            sram_wdata = fifo_rdata;
        end else if (own_rd) begin
            rd_gnt     = 1'b1;
            sram_addr  = rd_addr;
        end
    end

    // Capture FSM, write pointer, discard counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wr_ptr      <= CAP_BASE;
            discard_cnt <= '0;
            cap_ovf     <= 1'b0;
        end else if (cap_start) begin
            state       <= ST_CAPTURE;
            wr_ptr      <= CAP_BASE;
            discard_cnt <= 16'(DISCARD_FIRST);
            cap_ovf     <= 1'b0;
        end else begin
            if (own_wr) begin
                if (last_wr) begin
                    state <= ST_FULL;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (discard) begin
                discard_cnt <= discard_cnt - 1'b1;
            end
            if (ovf_set) begin
                cap_ovf <= 1'b1;
            end
        end
    end

    // Remember the last driven address/data so an idle port holds them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            addr_hold  <= sram_addr;
            wdata_hold <= sram_wdata;
        end
    end

    // Read response: valid one cycle after the grant, data held until the next response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_hold    <= '0;
        end else begin
            rd_valid_q <= rd_gnt;
            if (rd_valid_q) begin
                rd_hold <= sram_rdata;
            end
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (own_wr),
        .wdata (adc_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
